// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM
// states, byte-strobe generation, misalignment test and load extension.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Strobes for an 8-lane bus; narrower buses truncate the result.
  function automatic logic [7:0] lsu_wmask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      default: return |lo[2:0];
    endcase
  endfunction

  // Selects the low 8<<size bits of an already lane-0-aligned value and extends to 64.
  function automatic logic [63:0] lsu_load_ext(input logic [63:0] v, input logic [1:0] size,
                                               input logic uns);
    case (size)
      SZ_B:    return uns ? {56'd0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
      SZ_H:    return uns ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
      SZ_W:    return uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_align.sv
// Combinational load alignment: shift the bus word down by the byte offset,
// then select and sign/zero-extend the accessed field to XLEN.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  i_rdata,
  input  logic [OFF_W-1:0] i_off,
  input  logic [1:0]       i_size,
  input  logic             i_uns,
  output logic [XLEN-1:0]  o_data
);

  logic [XLEN-1:0] w_shift;

  assign w_shift = i_rdata >> {i_off, 3'b000};
  // Extension is done at 64 bits; on a 32-bit datapath the word case then
  // truncates back to the original value.
  assign o_data  = XLEN'(lsu_load_ext(64'(w_shift), i_size, i_uns));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit front end: captures one request, drives an aligned bus
// transaction with byte strobes, and returns extended load data or an error.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32,
  parameter int STRB_W = XLEN/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int OFF_W = $clog2(STRB_W);

  lsu_state_e        r_state, w_next;
  logic              r_we, r_uns, r_err;
  logic [1:0]        r_size;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_rdata;
  logic [STRB_W-1:0] r_wmask;

  logic              w_accept, w_bad;
  logic [OFF_W-1:0]  w_off;
  logic [STRB_W-1:0] w_mask;
  logic [XLEN-1:0]   w_wshift, w_load;

  assign w_accept = req_valid && req_ready;
  assign w_off    = req_addr[OFF_W-1:0];
  assign w_bad    = lsu_misaligned(req_size, req_addr[2:0]) || (req_size == SZ_D && XLEN == 32);
  assign w_mask   = STRB_W'(lsu_wmask(req_size, 3'(w_off)));
  assign w_wshift = req_wdata << {w_off, 3'b000};

  // Handshake outputs decode straight from state so reset drops them at once.
  assign req_ready  = (r_state == ST_IDLE);
  assign mem_valid  = (r_state == ST_ISSUE);
  assign resp_valid = (r_state == ST_RESP);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_wmask  = r_wmask;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid)  w_next = w_bad ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (mem_ready)  w_next = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (mem_rvalid) w_next = ST_RESP;
      ST_RESP:  if (resp_ready) w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= SZ_B;
      r_off   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_uns   <= req_unsigned;
      r_err   <= w_bad;
      r_size  <= req_size;
      r_off   <= w_off;
      r_addr  <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      r_wdata <= w_wshift;
      r_wmask <= req_we ? w_mask : '0;
      r_rdata <= '0;
    end else if (r_state == ST_WAIT && mem_rvalid) begin
      r_rdata <= w_load;
    end
  end

  lsu_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .i_rdata (mem_rdata),
    .i_off   (r_off),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .o_data  (w_load)
  );

endmodule
